// File: rtl/bcd_seg7_decoder.sv
// Registered BCD/hex to 7-segment decoder for one display digit.
// Lamp test beats blank, which beats the decode; outputs update one clk after input.
module bcd_seg7_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit HEX_MODE       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  input  logic       dp_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err
);

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic       err;
  } seg_out_t;

  // Pattern with every segment and the dp dark, in board polarity.
  localparam seg_out_t OUT_OFF = '{seg: {7{SEG_ACTIVE_LOW}}, dp: SEG_ACTIVE_LOW, err: 1'b0};

  logic [6:0] pat_ah;
  logic       code_ok;
  seg_out_t   nxt, q;

  always_comb begin
    pat_ah  = 7'h00;
    code_ok = 1'b1;
    case (bcd)
      4'd0:  pat_ah = 7'h3F;
      4'd1:  pat_ah = 7'h06;
      4'd2:  pat_ah = 7'h5B;
      4'd3:  pat_ah = 7'h4F;
      4'd4:  pat_ah = 7'h66;
      4'd5:  pat_ah = 7'h6D;
      4'd6:  pat_ah = 7'h7D;
      4'd7:  pat_ah = 7'h07;
      4'd8:  pat_ah = 7'h7F;
      4'd9:  pat_ah = 7'h6F;
      4'd10: pat_ah = 7'h77;
      4'd11: pat_ah = 7'h7C;
      4'd12: pat_ah = 7'h39;
      4'd13: pat_ah = 7'h5E;
      4'd14: pat_ah = 7'h79;
      default: pat_ah = 7'h71;
    endcase
    // Without hex support, letters are dark and flagged.
    if (!HEX_MODE && bcd > 4'd9) begin
      pat_ah  = 7'h00;
      code_ok = 1'b0;
    end
  end

  always_comb begin
    nxt = OUT_OFF;
    if (lamp_test) begin
      nxt.seg = {7{~SEG_ACTIVE_LOW}};
      nxt.dp  = ~SEG_ACTIVE_LOW;
    end else if (!blank) begin
      nxt.seg = pat_ah ^ {7{SEG_ACTIVE_LOW}};
      nxt.dp  = dp_in ^ SEG_ACTIVE_LOW;
      nxt.err = ~code_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= OUT_OFF;
    else if (en) q <= nxt;
  end

  assign seg = q.seg;
  assign dp  = q.dp;
  assign err = q.err;

endmodule

// File: tb/tb_bcd_seg7_decoder.sv
// Directed bench for bcd_seg7_decoder: default, hex-mode and active-high instances
// share one stimulus; each instance has its own hand-computed expectations.
module tb_bcd_seg7_decoder;

  logic       clk = 1'b0;
  logic       rst, en, blank, lamp_test, dp_in;
  logic [3:0] bcd;
  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2, err0, err1, err2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_seg7_decoder u_def (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .blank(blank), .lamp_test(lamp_test),
    .dp_in(dp_in), .seg(seg0), .dp(dp0), .err(err0));

  bcd_seg7_decoder #(.SEG_ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .blank(blank), .lamp_test(lamp_test),
    .dp_in(dp_in), .seg(seg1), .dp(dp1), .err(err1));

  bcd_seg7_decoder #(.SEG_ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_ah (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .blank(blank), .lamp_test(lamp_test),
    .dp_in(dp_in), .seg(seg2), .dp(dp2), .err(err2));

  typedef struct {
    logic [3:0] bcd;
    logic       dp_in;
    logic [6:0] s_def;
    logic       e_def;
    logic [6:0] s_hex;
    logic [6:0] s_ah;
  } vec_t;

  vec_t vecs[17];

  logic [6:0] t_def [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
                             7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30};
  logic       t_err [17] = '{0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 0};
  logic [6:0] t_hex [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
                             7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h30};
  logic [6:0] t_ah  [17] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                             7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h4F};

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Checks the default instance and the active-high instance together.
  task automatic chk_pair(input string nm, input logic [6:0] s0, input logic d0, input logic e0,
                          input logic [6:0] s2, input logic d2);
    chk({nm, " def seg"}, {1'b0, seg0}, {1'b0, s0});
    chk({nm, " def dp"},  {7'd0, dp0},  {7'd0, d0});
    chk({nm, " def err"}, {7'd0, err0}, {7'd0, e0});
    chk({nm, " ah seg"},  {1'b0, seg2}, {1'b0, s2});
    chk({nm, " ah dp"},   {7'd0, dp2},  {7'd0, d2});
  endtask

  initial begin
    for (int i = 0; i < 17; i++) begin
      vecs[i].bcd   = (i == 16) ? 4'd3 : 4'(i);
      vecs[i].dp_in = i[0];
      vecs[i].s_def = t_def[i];
      vecs[i].e_def = t_err[i];
      vecs[i].s_hex = t_hex[i];
      vecs[i].s_ah  = t_ah[i];
    end

    // Reset wins over lamp test.
    rst = 1'b1; en = 1'b1; bcd = 4'd8; blank = 1'b0; lamp_test = 1'b1; dp_in = 1'b1;
    cyc(); cyc();
    chk_pair("reset", 7'h7F, 1'b1, 1'b0, 7'h00, 1'b0);
    rst = 1'b0; lamp_test = 1'b0; dp_in = 1'b0;
    cyc();
    chk_pair("post-reset 8", 7'h00, 1'b1, 1'b0, 7'h7F, 1'b0);

    // Reset overrides a deasserted enable.
    rst = 1'b1; en = 1'b0;
    cyc();
    chk_pair("reset en0", 7'h7F, 1'b1, 1'b0, 7'h00, 1'b0);
    rst = 1'b0; en = 1'b1;

    // Back-to-back sweep; before each edge the previous result must still be showing.
    for (int i = 0; i < 17; i++) begin
      bcd = vecs[i].bcd; dp_in = vecs[i].dp_in;
      if (i > 0) begin
        #3;
        chk($sformatf("latency hold %0d", i), {1'b0, seg0}, {1'b0, vecs[i-1].s_def});
      end
      cyc();
      chk_pair($sformatf("sweep %0d", i), vecs[i].s_def, ~vecs[i].dp_in, vecs[i].e_def,
               vecs[i].s_ah, vecs[i].dp_in);
      chk($sformatf("sweep %0d hex seg", i), {1'b0, seg1}, {1'b0, vecs[i].s_hex});
      chk($sformatf("sweep %0d hex err", i), {7'd0, err1}, 8'd0);
      chk($sformatf("sweep %0d hex dp", i),  {7'd0, dp1},  {7'd0, ~vecs[i].dp_in});
    end

    // Priority: lamp_test > blank > decode.
    bcd = 4'd5; lamp_test = 1'b1; blank = 1'b1; dp_in = 1'b0;
    cyc();
    chk_pair("prio lamp", 7'h00, 1'b0, 1'b0, 7'h7F, 1'b1);
    lamp_test = 1'b0;
    cyc();
    chk_pair("prio blank", 7'h7F, 1'b1, 1'b0, 7'h00, 1'b0);
    blank = 1'b0;
    cyc();
    chk_pair("prio decode", 7'h12, 1'b1, 1'b0, 7'h6D, 1'b0);

    // Lamp test and blank both clear err even on an invalid code.
    bcd = 4'd12; lamp_test = 1'b1;
    cyc();
    chk("lamp invalid err", {7'd0, err0}, 8'd0);
    lamp_test = 1'b0; blank = 1'b1;
    cyc();
    chk("blank invalid err", {7'd0, err0}, 8'd0);
    blank = 1'b0;

    // Enable hold: outputs frozen while inputs churn.
    bcd = 4'd2;
    cyc();
    chk("hold load 2", {1'b0, seg0}, 8'h24);
    en = 1'b0; bcd = 4'd7; blank = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("hold %0d", k), {1'b0, seg0}, 8'h24);
    end
    en = 1'b1; blank = 1'b0;
    cyc();
    chk("hold release", {1'b0, seg0}, 8'h78);

    // err holds too.
    bcd = 4'd13;
    cyc();
    chk("err set", {7'd0, err0}, 8'd1);
    en = 1'b0; bcd = 4'd1;
    cyc(); cyc();
    chk("err hold", {7'd0, err0}, 8'd1);
    chk("err hold seg", {1'b0, seg0}, 8'h7F);
    en = 1'b1;

    // Active-high polarity with dp toggling.
    bcd = 4'd0; dp_in = 1'b1;
    cyc();
    chk("ah 0 seg", {1'b0, seg2}, 8'h3F);
    chk("ah 0 dp",  {7'd0, dp2},  8'd1);
    dp_in = 1'b0;
    #3;
    chk("ah dp before edge", {7'd0, dp2}, 8'd1);
    cyc();
    chk("ah dp cleared", {7'd0, dp2}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_decoder.md
Name: bcd_seg7_decoder

Overview:
Registered BCD/hex-to-seven-segment decoder: one 4-bit digit code in, one cycle later a segment pattern for one 7-segment digit out. Eight instances, one per digit, sit ahead of the display multiplexer that scans the board's 8-digit common-anode display. The block also provides blanking, lamp test, decimal-point passthrough and an invalid-code flag.

Parameters:
SEG_ACTIVE_LOW, 1, 1: a lit segment is driven 0 (common-anode board); 0: a lit segment is driven 1.
HEX_MODE, 0, 0: codes 10–15 are invalid and blank the digit; 1: codes 10–15 decode to A b C d E F.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  output-register load enable; when 0 the outputs hold.
bcd  input  4  digit code.
blank  input  1  force all segments and dp off.
lamp_test  input  1  force all segments and dp on.
dp_in  input  1  decimal point request, active-high.
seg  output  7  segment drive {g,f,e,d,c,b,a}, so seg[0]=a and seg[6]=g; polarity set by SEG_ACTIVE_LOW.
dp  output  1  decimal point drive, same polarity as seg.
err  output  1  registered flag, active-high: the last loaded code was invalid.

Behaviour:
- Single clock domain (clk). Synchronous reset, active-high (rst).
- All outputs are registered. Latency from input to output is exactly 1 clk when en=1.
- Reset: on a rising edge with rst=1, all segments go off and dp goes off, i.e. seg=7'h7F and dp=1 when SEG_ACTIVE_LOW=1; err=0. Reset overrides en and all other inputs. When rst falls, the next enabled edge loads a normal decode.
- Per-edge priority when rst=0 and en=1:
  - lamp_test=1: all on (seg=7'h00, dp=0 when active-low); err=0.
  - else blank=1: all off; err=0.
  - else decode bcd as below; dp = dp_in with polarity applied.
- en=0: seg, dp and err hold their previous values; bcd, blank and lamp_test are ignored.
- Decode table, active-high form {g..a}, then inverted when SEG_ACTIVE_LOW=1:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - HEX_MODE=1 adds A=77, b=7C, C=39, d=5E, E=79, F=71; err=0 for all codes.
  - HEX_MODE=0: codes 10–15 give all segments off, dp follows dp_in, err=1.
- Active-low encodings: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- The decode path has no internal state other than the output registers; back-to-back different codes on consecutive enabled edges each appear one cycle later with no gaps.
- X-free: every output register holds a defined value after the first reset edge.

Test Plan:
- Reset: assert rst 2 cycles with bcd=8 and lamp_test=1 -> seg=7F, dp=1, err=0 (default parameters); deassert, bcd=8, lamp_test=0 -> one cycle later seg=00.
- Full BCD sweep, defaults: bcd 0..9 on consecutive cycles, en=1 -> seg sequence 40,79,24,30,19,12,02,78,00,10, each lagging its input by exactly 1 cycle, err=0 throughout.
- Invalid codes: HEX_MODE=0, bcd=10..15 -> seg=7F, err=1; then bcd=3 -> seg=30, err=0. Rerun with HEX_MODE=1, bcd=10..15 -> 08,03,46,21,06,0E, err=0.
- Priority: bcd=5 with lamp_test=1 and blank=1 -> seg=00, dp=0; drop lamp_test -> seg=7F, dp=1; drop blank -> seg=12.
- Enable hold: load bcd=2 (seg=24), set en=0 and change bcd to 7 for 5 cycles -> seg stays 24; set en=1 -> next cycle seg=78.
- Polarity and dp: SEG_ACTIVE_LOW=0, bcd=0, dp_in=1 -> seg=3F, dp=1; dp_in=0 -> dp=0 one cycle later.
